// File: rtl/dled_scan_ctrl.sv
// Eight-digit multiplexed seven-segment scan controller with frame-synchronous shadow update.
// Optional inter-digit blanking is built when DLED_BLANK_EN is defined.
module dled_scan_ctrl #(
    parameter int unsigned SCAN_DIV  = 48000,
    parameter int unsigned BLANK_CYC = 16
) (
    input  logic        clock,
    input  logic        rst,
    input  logic        en,
    input  logic        upd_req,
    input  logic [31:0] data,
    input  logic [7:0]  dp,
    output logic        upd_ack,
    output logic [7:0]  seg,
    output logic [7:0]  dig,
    output logic        frame_done
);

    localparam logic [19:0] PRESC_MAX = 20'(SCAN_DIV - 1);

`ifdef DLED_BLANK_EN
    localparam logic [7:0] BLANK_LAST = 8'(BLANK_CYC - 1);

    typedef enum logic [0:0] {
        SHOW  = 1'b0,
        BLANK = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  blank_q, blank_d;
`endif

    logic [19:0] presc_q, presc_d;
    logic [2:0]  idx_q, idx_d;
    logic [31:0] data_sh_q, data_sh_d;
    logic [7:0]  dp_sh_q, dp_sh_d;
    logic [7:0]  seg_q, seg_d;
    logic [7:0]  dig_q, dig_d;
    logic        upd_ack_q, upd_ack_d;
    logic        frame_done_q, frame_done_d;
    logic        tick_s;
    logic        show_s;
    logic        capture_s;
    logic [3:0]  nib_s;

    // Active-low segment pattern g..a for one hex nibble.
    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] r;
        case (n)
            4'h0:    r = 7'h40;
            4'h1:    r = 7'h79;
            4'h2:    r = 7'h24;
            4'h3:    r = 7'h30;
            4'h4:    r = 7'h19;
            4'h5:    r = 7'h12;
            4'h6:    r = 7'h02;
            4'h7:    r = 7'h78;
            4'h8:    r = 7'h00;
            4'h9:    r = 7'h10;
            4'hA:    r = 7'h08;
            4'hB:    r = 7'h03;
            4'hC:    r = 7'h46;
            4'hD:    r = 7'h21;
            4'hE:    r = 7'h06;
            4'hF:    r = 7'h0E;
            default: r = 7'h7F;
        endcase
        return r;
    endfunction

    assign tick_s = (presc_q == PRESC_MAX);
`ifdef DLED_BLANK_EN
    assign show_s = (state_q == SHOW);
`else
    assign show_s = 1'b1;
`endif

    // Next-state, shadow capture and output decode; outputs are decoded from the current state.
    always_comb begin
        presc_d      = presc_q;
        idx_d        = idx_q;
        data_sh_d    = data_sh_q;
        dp_sh_d      = dp_sh_q;
        upd_ack_d    = 1'b0;
        frame_done_d = 1'b0;
        seg_d        = 8'hFF;
        dig_d        = 8'hFF;
        capture_s    = 1'b0;
        nib_s        = 4'h0;
`ifdef DLED_BLANK_EN
        state_d      = state_q;
        blank_d      = blank_q;
`endif
        if (!en) begin
            presc_d   = 20'd0;
            idx_d     = 3'd0;
`ifdef DLED_BLANK_EN
            state_d   = SHOW;
            blank_d   = 8'd0;
`endif
            capture_s = upd_req && !upd_ack_q;
        end else if (show_s) begin
            // Loads land only at the very first cycle of a frame, so digits never tear mid-frame.
            capture_s = upd_req && !upd_ack_q && (idx_q == 3'd0) && (presc_q == 20'd0);
            if (tick_s) begin
                presc_d      = 20'd0;
                frame_done_d = (idx_q == 3'd7);
`ifdef DLED_BLANK_EN
                state_d      = BLANK;
                blank_d      = 8'd0;
`else
                idx_d        = idx_q + 3'd1;
`endif
            end else begin
                presc_d = presc_q + 20'd1;
            end
        end else begin
`ifdef DLED_BLANK_EN
            presc_d = 20'd0;
            if (blank_q == BLANK_LAST) begin
                state_d = SHOW;
                idx_d   = idx_q + 3'd1;
                blank_d = 8'd0;
            end else begin
                blank_d = blank_q + 8'd1;
            end
`endif
        end

        if (capture_s) begin
            data_sh_d = data;
            dp_sh_d   = dp;
            upd_ack_d = 1'b1;
        end else begin
            upd_ack_d = 1'b0;
        end

        nib_s = data_sh_d[{idx_q, 2'b00} +: 4];
        if (en && show_s) begin
            dig_d = ~(8'h01 << idx_q);
            seg_d = {~dp_sh_d[idx_q], hex7(nib_s)};
        end else begin
            dig_d = 8'hFF;
            seg_d = 8'hFF;
        end
    end

    // State, shadow and registered output flops.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            presc_q      <= 20'd0;
            idx_q        <= 3'd0;
            data_sh_q    <= 32'd0;
            dp_sh_q      <= 8'd0;
            seg_q        <= 8'hFF;
            dig_q        <= 8'hFF;
            upd_ack_q    <= 1'b0;
            frame_done_q <= 1'b0;
`ifdef DLED_BLANK_EN
            state_q      <= SHOW;
            blank_q      <= 8'd0;
`endif
        end else begin
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            data_sh_q    <= data_sh_d;
            dp_sh_q      <= dp_sh_d;
            seg_q        <= seg_d;
            dig_q        <= dig_d;
            upd_ack_q    <= upd_ack_d;
            frame_done_q <= frame_done_d;
`ifdef DLED_BLANK_EN
            state_q      <= state_d;
            blank_q      <= blank_d;
`endif
        end
    end

    assign seg        = seg_q;
    assign dig        = dig_q;
    assign upd_ack    = upd_ack_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_dled_scan_ctrl.sv
// Directed self-checking bench for dled_scan_ctrl with SCAN_DIV=4, BLANK_CYC=2.
// Expected timing follows whether DLED_BLANK_EN is defined for the build.
module tb_dled_scan_ctrl;

`ifdef DLED_BLANK_EN
    localparam int BL = 2;
`else
    localparam int BL = 0;
`endif
    localparam int PER   = 4 + BL;
    localparam int FRAME = 8 * PER;

    logic        clock;
    logic        rst;
    logic        en;
    logic        upd_req;
    logic [31:0] data;
    logic [7:0]  dp;
    logic        upd_ack;
    logic [7:0]  seg;
    logic [7:0]  dig;
    logic        frame_done;

    int n_tests;
    int n_fail;

    dled_scan_ctrl #(
        .SCAN_DIV  (4),
        .BLANK_CYC (2)
    ) dut (
        .clock      (clock),
        .rst        (rst),
        .en         (en),
        .upd_req    (upd_req),
        .data       (data),
        .dp         (dp),
        .upd_ack    (upd_ack),
        .seg        (seg),
        .dig        (dig),
        .frame_done (frame_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    // Leaves the bench at the first cycle of a fresh frame (cycle 0 of digit 0).
    task automatic start_frame();
        en = 1'b0;
        step();
        en = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; upd_req = 1'b0; data = 32'd0; dp = 8'd0;
        #1;
        n_tests++;
        if ({seg, dig, upd_ack, frame_done} !== {8'hFF, 8'hFF, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset: seg=%h dig=%h ack=%b fd=%b, want FF FF 0 0", seg, dig, upd_ack, frame_done);
        end
        @(negedge clock);
        @(negedge clock);
        rst = 1'b0;
    endtask

    task automatic test_scan();
        logic [7:0] ed, es;
        en = 1'b1;
        step();
        for (int c = 0; c <= PER; c++) begin
            if (c < 4)        begin ed = 8'hFE; es = 8'hC0; end
            else if (c < PER) begin ed = 8'hFF; es = 8'hFF; end
            else              begin ed = 8'hFD; es = 8'hC0; end
            n_tests++;
            if (dig !== ed || seg !== es) begin
                n_fail++;
                $display("FAIL scan c=%0d: dig=%h seg=%h, want %h %h", c, dig, seg, ed, es);
            end
            step();
        end
    endtask

    task automatic test_frame_done();
        int pulses;
        logic efd;
        pulses = 0;
        start_frame();
        for (int c = 0; c <= 2 * FRAME + 4; c++) begin
            efd = ((c % FRAME) == 7 * PER + 3);
            if (frame_done === 1'b1) pulses++;
            n_tests++;
            if (frame_done !== efd) begin
                n_fail++;
                $display("FAIL frame_done c=%0d: got %b, want %b", c, frame_done, efd);
            end
            if (efd) begin
                n_tests++;
                if (dig !== 8'h7F) begin
                    n_fail++;
                    $display("FAIL fd_digit c=%0d: dig=%h, want 7F", c, dig);
                end
            end
            step();
        end
        n_tests++;
        if (pulses != 2) begin
            n_fail++;
            $display("FAIL fd_count: got %0d, want 2", pulses);
        end
    endtask

    task automatic test_update();
        int c;
        start_frame();
        for (c = 0; c < 10; c++) step();
        upd_req = 1'b1; data = 32'h76543210; dp = 8'h01;
        while (c < 10 * FRAME && upd_ack !== 1'b1) begin
            step();
            c++;
        end
        n_tests++;
        if (c != FRAME) begin
            n_fail++;
            $display("FAIL upd_ack_time: got cycle %0d, want %0d", c, FRAME);
        end
        n_tests++;
        if (dig !== 8'hFE || seg !== 8'h40) begin
            n_fail++;
            $display("FAIL upd_digit0: dig=%h seg=%h, want FE 40", dig, seg);
        end
        upd_req = 1'b0;
        step();
        n_tests++;
        if (upd_ack !== 1'b0 || seg !== 8'h40) begin
            n_fail++;
            $display("FAIL upd_one_pulse: ack=%b seg=%h, want 0 40", upd_ack, seg);
        end
        for (int i = 1; i < PER; i++) step();
        n_tests++;
        if (dig !== 8'hFD || seg !== 8'hF9) begin
            n_fail++;
            $display("FAIL upd_digit1: dig=%h seg=%h, want FD F9", dig, seg);
        end
        for (int i = 0; i < PER; i++) step();
        n_tests++;
        if (dig !== 8'hFB || seg !== 8'hA4) begin
            n_fail++;
            $display("FAIL upd_digit2: dig=%h seg=%h, want FB A4", dig, seg);
        end
    endtask

    task automatic test_hold_req();
        en = 1'b0;
        step();
        en = 1'b1; upd_req = 1'b1; data = 32'h00000005; dp = 8'h00;
        step();
        for (int c = 0; c <= FRAME + 1; c++) begin
            n_tests++;
            if (upd_ack !== ((c % FRAME) == 0)) begin
                n_fail++;
                $display("FAIL hold_req c=%0d: ack=%b, want %b", c, upd_ack, ((c % FRAME) == 0));
            end
            step();
        end
        upd_req = 1'b0;
        step();
    endtask

    task automatic test_en_off();
        start_frame();
        for (int i = 0; i < 3 * PER + 1; i++) step();
        n_tests++;
        if (dig !== 8'hF7) begin
            n_fail++;
            $display("FAIL en_off_pre: dig=%h, want F7", dig);
        end
        en = 1'b0;
        step();
        n_tests++;
        if (dig !== 8'hFF || seg !== 8'hFF) begin
            n_fail++;
            $display("FAIL en_off_blank: dig=%h seg=%h, want FF FF", dig, seg);
        end
        upd_req = 1'b1; data = 32'h89ABCDEF; dp = 8'hFF;
        step();
        n_tests++;
        if (upd_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL en_off_ack: ack=%b, want 1", upd_ack);
        end
        upd_req = 1'b0;
        step();
        n_tests++;
        if (upd_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL en_off_ack_drop: ack=%b, want 0", upd_ack);
        end
        en = 1'b1;
        step();
        n_tests++;
        if (dig !== 8'hFE || seg !== 8'h0E) begin
            n_fail++;
            $display("FAIL en_on: dig=%h seg=%h, want FE 0E", dig, seg);
        end
    endtask

    task automatic test_rst_mid();
        start_frame();
        step();
        #2;
        rst = 1'b1;
        #1;
        n_tests++;
        if (dig !== 8'hFF || seg !== 8'hFF) begin
            n_fail++;
            $display("FAIL rst_dwell: dig=%h seg=%h, want FF FF", dig, seg);
        end
        @(negedge clock);
        rst = 1'b0;
        step();
        for (int i = 0; i < 3; i++) step();
        #2;
        rst = 1'b1;
        #1;
        n_tests++;
        if ({dig, seg, upd_ack, frame_done} !== {8'hFF, 8'hFF, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL rst_blank: dig=%h seg=%h ack=%b fd=%b, want FF FF 0 0", dig, seg, upd_ack, frame_done);
        end
        for (int i = 0; i < 2; i++) begin
            step();
            n_tests++;
            if (upd_ack !== 1'b0 || frame_done !== 1'b0 || dig !== 8'hFF) begin
                n_fail++;
                $display("FAIL rst_hold: ack=%b fd=%b dig=%h, want 0 0 FF", upd_ack, frame_done, dig);
            end
        end
        rst = 1'b0;
        step();
        n_tests++;
        if (dig !== 8'hFE || seg !== 8'hC0) begin
            n_fail++;
            $display("FAIL rst_resume: dig=%h seg=%h, want FE C0", dig, seg);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_scan();
        test_frame_done();
        test_update();
        test_hold_req();
        test_en_off();
        test_rst_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dled_scan_ctrl.md
DLED_SCAN_CTRL -- requirements
Module: dled_scan_ctrl

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 48000, meaning clock cycles per digit dwell tick (valid range 2..2^20).
REQ-002 SHALL have parameter BLANK_CYC, default 16, meaning clock cycles of inter-digit blanking (valid range 1..255).
REQ-003 SHALL have port clock, input, 1 bit: the single system clock; all logic is rising-edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port en, input, 1 bit: scan enable.
REQ-006 SHALL have port upd_req, input, 1 bit: request to load new display contents.
REQ-007 SHALL have port data, input, 32 bits: eight hex nibbles; nibble k = data[4k+3:4k] drives digit k.
REQ-008 SHALL have port dp, input, 8 bits: decimal point per digit, 1 = lit.
REQ-009 SHALL have port upd_ack, output, 1 bit: one-cycle pulse when data/dp are captured.
REQ-010 SHALL have port seg, output, 8 bits, active-low: seg[6:0] = segments g..a, seg[7] = dp.
REQ-011 SHALL have port dig, output, 8 bits, active-low one-hot digit select.
REQ-012 SHALL have port frame_done, output, 1 bit: one-cycle pulse when digit 7 dwell ends.

Function
REQ-013 SHALL run a prescaler 0..SCAN_DIV-1 while en=1 and assert an internal tick on the count SCAN_DIV-1, wrapping to 0.
REQ-014 SHALL use FSM states SHOW and BLANK; in SHOW, dig drives a low on bit idx only and seg shows the decoded shadow nibble idx.
REQ-015 SHALL, on a tick in SHOW, enter BLANK (dig=8'hFF, seg=8'hFF) for exactly BLANK_CYC cycles, then increment idx mod 8, return to SHOW and restart the prescaler.
REQ-016 SHALL hold the prescaler at 0 while in BLANK.
REQ-017 SHALL pulse frame_done for one cycle on the tick that ends the idx=7 dwell.
REQ-018 SHALL decode nibbles to the standard active-low hex map: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E (bit 7 shown as 1), with seg[7]=~dp_shadow[idx].
REQ-019 SHALL, while upd_req=1, capture data/dp into the shadow registers and pulse upd_ack on the first cycle where idx=0, the FSM is in SHOW, and the prescaler is 0; the requester holds data stable until upd_ack.
REQ-020 SHALL capture at most once per frame; upd_req still high after upd_ack is served at the next frame start.
REQ-021 SHALL, when en=0, force dig=8'hFF and seg=8'hFF, set idx=0, state SHOW, and prescaler 0; shadows are kept; while upd_req=1, capture immediately and pulse upd_ack.
REQ-022 SHALL, on en rising, show digit 0 on the same cycle, with its prescaler starting from 0.
REQ-023 SHALL register seg and dig, so outputs reflect state one cycle after the state change, with no combinational glitches.

Reset
REQ-024 SHALL, on rst=1 (asynchronous), set seg=8'hFF, dig=8'hFF, upd_ack=0, frame_done=0, idx=0, state=SHOW, prescaler=0, and all shadow data/dp=0.
REQ-025 SHALL, on rst mid-dwell or mid-blank, abandon the frame with no upd_ack or frame_done pulse; scanning resumes from digit 0 after release.

Configuration
REQ-026 SHALL support macro DLED_BLANK_EN: when defined, the BLANK state per REQ-015 is built.
REQ-027 SHALL, without DLED_BLANK_EN, omit the BLANK state and BLANK_CYC logic: a tick in SHOW increments idx directly and dig switches on the next cycle with no blanking interval.

Verification (SCAN_DIV=4, BLANK_CYC=2, DLED_BLANK_EN defined unless noted)
REQ-028 SHALL cover: rst pulse, then en=1, data=0 -> dig=FE and seg=C0 for 4 cycles, then FF/FF for 2 cycles, then dig=FD.
REQ-029 SHALL cover: upd_req=1, data=32'h76543210, dp=8'h01 mid-frame -> upd_ack only at the next idx=0 start; then digit0 seg=40, digit1 seg=F9.
REQ-030 SHALL cover: full frame -> frame_done pulses once every 8*(4+2)=48 cycles, coincident with the end of the digit-7 dwell.
REQ-031 SHALL cover: en=0 mid-dwell on digit 3 -> dig=FF/seg=FF the next cycle; en=1 -> dig=FE; upd_req during en=0 -> upd_ack within 1 cycle.
REQ-032 SHALL cover: rst asserted during BLANK -> outputs FF immediately (asynchronous), shadows 0, no stray pulses.
REQ-033 SHALL cover: DLED_BLANK_EN undefined -> dig steps FE->FD after exactly 4 cycles, and frame_done period is 32 cycles.
